// File: rtl/path_replayer_if.sv
// path_replayer_if: groups the replayer's start/direction handshake, maze read port and status outputs.
// Coordinate width CW and step counter width SW must match the attached path_replayer instance.
`default_nettype none

interface path_replayer_if #(
  parameter int CW = 4,
  parameter int SW = 8
);
  logic          start;
  logic          dir_valid;
  logic [1:0]    dir;
  logic          dir_last;
  logic          dir_ready;
  logic          mem_rd;
  logic [CW-1:0] mem_x;
  logic [CW-1:0] mem_y;
  logic          mem_dout;
  logic [CW-1:0] cur_x;
  logic [CW-1:0] cur_y;
  logic [SW-1:0] step_count;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  // Replayer side
  modport slave (
    input  start, dir_valid, dir, dir_last, mem_dout,
    output dir_ready, mem_rd, mem_x, mem_y, cur_x, cur_y,
           step_count, busy, done, err, err_code
  );

  // Solver / maze-memory side
  modport master (
    output start, dir_valid, dir, dir_last, mem_dout,
    input  dir_ready, mem_rd, mem_x, mem_y, cur_x, cur_y,
           step_count, busy, done, err, err_code
  );
endinterface

`default_nettype wire

// File: rtl/path_replayer.sv
// path_replayer: replays a 2-bit move stream from (0,0), checking walls and bounds, and flags done/err.
// Optional PATH_REPLAY_TRACE_EN adds a simulation-only trace of commits and the final verdict.
`default_nettype none

module path_replayer #(
  parameter int CW = 4,
  parameter int SW = 8
) (
  input  logic clk,
  input  logic rst,
  path_replayer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_READ = 3'd2,
    S_EVAL = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [CW-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [SW-1:0] step_q, step_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  logic [CW-1:0] nxt_x, nxt_y;
  logic          nxt_oob;

  // Candidate cell for the move on the bus; oob marks a step off the grid edge
  always_comb begin
    nxt_x   = cur_x_q;
    nxt_y   = cur_y_q;
    nxt_oob = 1'b0;
    case (bus.dir)
      2'b00: begin nxt_oob = (cur_y_q == '0); nxt_y = cur_y_q - 1'b1; end
      2'b01: begin nxt_oob = (cur_x_q == '1); nxt_x = cur_x_q + 1'b1; end
      2'b10: begin nxt_oob = (cur_x_q == '0); nxt_x = cur_x_q - 1'b1; end
      default: begin nxt_oob = (cur_y_q == '1); nxt_y = cur_y_q + 1'b1; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    step_d  = step_q;
    last_d  = last_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          cur_x_d = '0;
          cur_y_d = '0;
          step_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = 2'b00;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.dir_valid) begin
          last_d = bus.dir_last;
          if (nxt_oob) begin
            err_d   = 1'b1;
            code_d  = 2'b10;
            state_d = S_ERR;
          end else begin
            tgt_x_d = nxt_x;
            tgt_y_d = nxt_y;
            state_d = S_READ;
          end
        end
      end
      S_READ: state_d = S_EVAL;
      S_EVAL: begin
        if (bus.mem_dout) begin
          err_d   = 1'b1;
          code_d  = 2'b01;
          state_d = S_ERR;
        end else if (step_q == '1) begin
          err_d   = 1'b1;
          code_d  = 2'b11;
          state_d = S_ERR;
        end else begin
          cur_x_d = tgt_x_q;
          cur_y_d = tgt_y_q;
          step_d  = step_q + 1'b1;
          if (!last_q) begin
            state_d = S_WAIT;
          end else if (tgt_x_q == '1 && tgt_y_q == '1) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'b11;
            state_d = S_ERR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cur_x_q <= '0;
      cur_y_q <= '0;
      tgt_x_q <= '0;
      tgt_y_q <= '0;
      step_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      tgt_x_q <= tgt_x_d;
      tgt_y_q <= tgt_y_d;
      step_q  <= step_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Handshake and read strobe decode straight from state so reset drops them at once
  assign bus.dir_ready  = (state_q == S_WAIT);
  assign bus.mem_rd     = (state_q == S_READ);
  assign bus.mem_x      = tgt_x_q;
  assign bus.mem_y      = tgt_y_q;
  assign bus.cur_x      = cur_x_q;
  assign bus.cur_y      = cur_y_q;
  assign bus.step_count = step_q;
  assign bus.busy       = (state_q == S_WAIT) || (state_q == S_READ) || (state_q == S_EVAL);
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.err_code   = code_q;

`ifdef PATH_REPLAY_TRACE_EN
  logic [1:0] trc_dir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == S_WAIT && bus.dir_valid)
        trc_dir_q <= bus.dir;
      if (state_q == S_EVAL && !bus.mem_dout && step_q != '1)
        $display("path_replayer: step %0d dir %0d -> x=%0d y=%0d",
                 step_q + 1'b1, trc_dir_q, tgt_x_q, tgt_y_q);
      if (state_d != state_q && (state_d == S_DONE || state_d == S_ERR))
        $display("path_replayer: %s err_code=%0d",
                 (state_d == S_DONE) ? "done" : "error", code_d);
    end
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_path_replayer.sv
// tb_path_replayer: directed replay scenarios with a read-address scoreboard and a registered wall-memory model.
`default_nettype none

module tb_path_replayer;
  localparam int CW = 4;
  localparam int SW = 8;
  localparam int CLK_PERIOD = 10;

  typedef struct {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } rd_t;

  logic clk = 1'b0;
  logic rst;
  logic [255:0] walls;
  rd_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  time  prev_hs;
  time  last_hs;

  path_replayer_if #(.CW(CW), .SW(SW)) ifc ();

  path_replayer #(.CW(CW), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #(CLK_PERIOD/2) clk = ~clk;

  // Wall bit presented the cycle after a read strobe
  always @(posedge clk) begin
    if (ifc.mem_rd) ifc.mem_dout <= walls[{ifc.mem_y, ifc.mem_x}];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every read strobe must match the next expected target, and nothing may read unannounced
  always @(negedge clk) begin
    if (rst === 1'b1 && ifc.mem_rd === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", 32'd1, 32'd0);
      end else begin
        rd_t e;
        e = exp_q.pop_front();
        check("rd_x", 32'(ifc.mem_x), 32'(e.x));
        check("rd_y", 32'(ifc.mem_y), 32'(e.y));
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic send_move(input logic [1:0] d, input logic last, input bit do_read,
                           input int ex, input int ey);
    int k;
    rd_t e;
    @(negedge clk);
    ifc.dir_valid = 1'b1;
    ifc.dir       = d;
    ifc.dir_last  = last;
    k = 0;
    while (ifc.dir_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check("hs_timeout", 32'(k), 32'd0);
    if (do_read) begin
      e.x = CW'(ex);
      e.y = CW'(ey);
      exp_q.push_back(e);
    end
    @(posedge clk);
    prev_hs = last_hs;
    last_hs = $time;
    #1;
    ifc.dir_valid = 1'b0;
    ifc.dir_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (ifc.busy === 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check("idle_timeout", 32'(k), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cur_x"}, 32'(ifc.cur_x), 32'd0);
    check({tag, "_cur_y"}, 32'(ifc.cur_y), 32'd0);
    check({tag, "_step"},  32'(ifc.step_count), 32'd0);
    check({tag, "_ready"}, 32'(ifc.dir_ready), 32'd0);
    check({tag, "_mem_rd"}, 32'(ifc.mem_rd), 32'd0);
    check({tag, "_mem_xy"}, {24'd0, ifc.mem_x, ifc.mem_y}, 32'd0);
    check({tag, "_busy"},  32'(ifc.busy), 32'd0);
    check({tag, "_flags"}, {29'd0, ifc.done, ifc.err_code}, 32'd0);
    check({tag, "_err"},   32'(ifc.err), 32'd0);
  endtask

  // 15 moves east then 15 moves south, optionally with a stray start pulse mid-stream
  task automatic run_full_path(input bit pulse_mid);
    int k;
    pulse_start();
    check("full_busy_after_start", 32'(ifc.busy), 32'd1);
    for (int i = 0; i < 30; i++) begin
      if (pulse_mid && i == 5) begin
        k = 0;
        @(negedge clk);
        while (ifc.dir_ready !== 1'b1 && k < 20) begin
          @(negedge clk);
          k++;
        end
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        check("start_in_wait_step", 32'(ifc.step_count), 32'd5);
        check("start_in_wait_busy", 32'(ifc.busy), 32'd1);
      end
      if (i < 15) send_move(2'b01, 1'b0, 1'b1, i + 1, 0);
      else        send_move(2'b11, (i == 29), 1'b1, 15, i - 14);
      if (i > 0 && !(pulse_mid && i == 5))
        check("hs_spacing", 32'((last_hs - prev_hs) / CLK_PERIOD), 32'd3);
    end
    wait_idle();
    check("full_done", 32'(ifc.done), 32'd1);
    check("full_err", 32'(ifc.err), 32'd0);
    check("full_cur", {24'd0, ifc.cur_x, ifc.cur_y}, 32'hFF);
    check("full_step", 32'(ifc.step_count), 32'd30);
    check("full_code", 32'(ifc.err_code), 32'd0);
    check("full_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst           = 1'b0;
    walls         = '0;
    ifc.start     = 1'b0;
    ifc.dir_valid = 1'b0;
    ifc.dir       = 2'b00;
    ifc.dir_last  = 1'b0;
    ifc.mem_dout  = 1'b0;
    prev_hs       = 0;
    last_hs       = 0;
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Open maze, legal 30-move path to the goal
    run_full_path(1'b1);

    // First move north off the grid: no read, cur stays at origin
    pulse_start();
    send_move(2'b00, 1'b0, 1'b0, 0, 0);
    wait_idle();
    check("oob_err", 32'(ifc.err), 32'd1);
    check("oob_code", 32'(ifc.err_code), 32'd2);
    check("oob_cur", {24'd0, ifc.cur_x, ifc.cur_y}, 32'd0);
    check("oob_step", 32'(ifc.step_count), 32'd0);
    check("oob_done", 32'(ifc.done), 32'd0);
    check("oob_mem_hold", {24'd0, ifc.mem_x, ifc.mem_y}, 32'hFF);

    // Wall at (2,0)
    walls[{4'd0, 4'd2}] = 1'b1;
    pulse_start();
    send_move(2'b01, 1'b0, 1'b1, 1, 0);
    send_move(2'b01, 1'b0, 1'b1, 2, 0);
    wait_idle();
    check("wall_err", 32'(ifc.err), 32'd1);
    check("wall_code", 32'(ifc.err_code), 32'd1);
    check("wall_cur", {24'd0, ifc.cur_x, ifc.cur_y}, 32'h10);
    check("wall_step", 32'(ifc.step_count), 32'd1);
    walls = '0;

    // Final move lands short of the goal
    pulse_start();
    send_move(2'b01, 1'b1, 1'b1, 1, 0);
    wait_idle();
    check("short_code", 32'(ifc.err_code), 32'd3);
    check("short_err", 32'(ifc.err), 32'd1);
    check("short_done", 32'(ifc.done), 32'd0);
    check("short_cur", {24'd0, ifc.cur_x, ifc.cur_y}, 32'h10);
    check("short_step", 32'(ifc.step_count), 32'd1);

    // Asynchronous reset while a read is in flight
    pulse_start();
    send_move(2'b01, 1'b0, 1'b1, 1, 0);
    send_move(2'b11, 1'b0, 1'b1, 1, 1);
    check("midrst_in_read", 32'(ifc.mem_rd), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    run_full_path(1'b0);

    // Restart after done
    pulse_start();
    check("restart_done", 32'(ifc.done), 32'd0);
    check("restart_cur", {24'd0, ifc.cur_x, ifc.cur_y}, 32'd0);
    check("restart_step", 32'(ifc.step_count), 32'd0);
    check("restart_busy", 32'(ifc.busy), 32'd1);
    check("restart_ready", 32'(ifc.dir_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
